des_key_sched_seq: RTL and testbench

Sequential DES key scheduler that produces the sixteen 48-bit round subkeys one per handshake, in forward order (K1..K16) for encryption or reverse order (K16..K1) for decryption. It sits between the key input register and the Feistel round datapath, which consumes one subkey per round into the F-function and its S-boxes. Decrypt order is generated directly with right rotations rather than by buffering all sixteen subkeys.

---
 rtl/des_pkg.sv | 68 ++++++
 rtl/des_pc2.sv | 19 +
 rtl/des_key_sched_seq.sv | 141 ++++++++++++++
 tb/tb_des_key_sched_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, shift schedules, state type and rotator.
// Holds PC-1/PC-2, LS/RS schedules, widths, FSM enum and rot28 helper.
package des_pkg;

    localparam int HALF_W   = 28;
    localparam int CD_W     = 56;
    localparam int SUBKEY_W = 48;
    localparam int KEY_W    = 64;

    // Entries are FIPS 46-3 bit numbers (bit 1 = MSB).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left shifts for encrypt, indexed by the round being produced.
    localparam logic [1:0] LS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Right shifts for decrypt: RS[n] = LS[16-n], RS[0] = 0 since C16 = C0.
    localparam logic [1:0] RS [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // 28-bit circular rotate; FIPS bit 1 of the half sits at bit 27.
    function automatic logic [27:0] rot28(
        input logic [27:0] x,
        input logic [1:0]  n,
        input logic        right
    );
        logic [27:0] r;
        r = x;
        if (right) begin
            if (n == 2'd1) r = {x[0], x[27:1]};
            if (n == 2'd2) r = {x[1:0], x[27:2]};
        end else begin
            if (n == 2'd1) r = {x[26:0], x[27]};
            if (n == 2'd2) r = {x[25:0], x[27:26]};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: combinational 56-bit C||D to 48-bit subkey.
// Ports: cd (C in [55:28], D in [27:0]), subkey (FIPS bit 1 = [47]).
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    for (genvar j = 0; j < 48; j++) begin : g_bit
        assign subkey[47-j] = cd[56-PC2[j]];
    end

    // PC-2 drops FIPS bits 9,18,22,25,35,38,43,54 of C||D.
    logic [7:0] drop_unused;
    assign drop_unused = {cd[47], cd[38], cd[34], cd[31],
                          cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES key scheduler: one 48-bit subkey per valid/ready handshake,
// K1..K16 (decrypt=0) or K16..K1 (decrypt=1) via right rotations.
// Ports: clk, rst (sync, active high), start, decrypt, key[63:0] in;
// subkey[47:0], subkey_valid, round[3:0], busy, done, key_err out;
// subkey_ready in. Optional macro DES_KEY_PARITY_CHECK_EN enables
// odd-parity rejection of the key on start (key_err pulse).
module des_key_sched_seq
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done,
    output logic        key_err
);

    state_t      state;
    state_t      state_n;
    logic [27:0] c;
    logic [27:0] d;
    logic [27:0] c_n;
    logic [27:0] d_n;
    logic        dec;
    logic        dec_n;
    logic [3:0]  round_n;
    logic        valid_n;
    logic        busy_n;
    logic        done_n;
    logic        err_n;
    logic        load;
    logic [1:0]  shamt;
    logic [55:0] pc1_cd;
    logic [47:0] pc2_out;
    logic        key_bad;

    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign pc1_cd[55-j] = key[64-PC1[j]];
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic [7:0] byte_ok;
    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_ok[b] = ^key[8*b+7:8*b];
    end
    assign key_bad = ~&byte_ok;
`else
    // PC-1 discards the parity bits when the check is compiled out.
    logic [7:0] parity_unused;
    assign parity_unused = {key[56], key[48], key[40], key[32],
                            key[24], key[16], key[8], key[0]};
    assign key_bad = 1'b0;
`endif

    des_pc2 u_pc2 (
        .cd     ({c_n, d_n}),
        .subkey (pc2_out)
    );

    always_comb begin
        state_n = state;
        c_n     = c;
        d_n     = d;
        dec_n   = dec;
        round_n = round;
        valid_n = subkey_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        load    = 1'b0;
        shamt   = 2'd0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (key_bad) begin
                        err_n = 1'b1;
                    end else begin
                        shamt   = decrypt ? RS[0] : LS[0];
                        c_n     = rot28(pc1_cd[55:28], shamt, decrypt);
                        d_n     = rot28(pc1_cd[27:0], shamt, decrypt);
                        dec_n   = decrypt;
                        round_n = 4'd0;
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                        load    = 1'b1;
                        state_n = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (subkey_valid && subkey_ready) begin
                    if (round == 4'd15) begin
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        round_n = round + 4'd1;
                        shamt   = dec ? RS[round_n] : LS[round_n];
                        c_n     = rot28(c, shamt, dec);
                        d_n     = rot28(d, shamt, dec);
                        load    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            c            <= '0;
            d            <= '0;
            dec          <= 1'b0;
            subkey       <= '0;
            subkey_valid <= 1'b0;
            round        <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            key_err      <= 1'b0;
        end else begin
            state        <= state_n;
            c            <= c_n;
            d            <= d_n;
            dec          <= dec_n;
            subkey_valid <= valid_n;
            round        <= round_n;
            busy         <= busy_n;
            done         <= done_n;
            key_err      <= err_n;
            if (load) subkey <= pc2_out;
        end
    end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Self-checking bench for des_key_sched_seq: random keys, backpressure,
// abort, ignored start and parity cases against a DES schedule model.
module tb_des_key_sched_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        busy;
    logic        done;
    logic        key_err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] KAT     = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_BAD = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1      = 48'h1B02EFFC7072;
    localparam logic [47:0] K2      = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16     = 48'hCB3D8B0E17F5;

    always #5 clk = ~clk;

    des_key_sched_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .busy         (busy),
        .done         (done),
        .key_err      (key_err)
    );

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] exp_k [16];
    logic [47:0] got_k [16];
    logic [47:0] enc_k [16];
    logic        ab;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Forward DES schedule by cumulative shift; decrypt order is the list reversed.
    task automatic model(input logic [63:0] k, input logic dec);
        logic [27:0] c0;
        logic [27:0] d0;
        logic [55:0] cd;
        logic [47:0] sk;
        int          s;
        for (int i = 0; i < 28; i++) begin
            c0[5'(27-i)] = k[6'(64-pc1_t[i])];
            d0[5'(27-i)] = k[6'(64-pc1_t[i+28])];
        end
        s = 0;
        for (int r = 0; r < 16; r++) begin
            s = s + shifts[r];
            for (int i = 0; i < 28; i++) begin
                cd[6'(55-i)] = c0[5'(27-((i+s)%28))];
                cd[6'(27-i)] = d0[5'(27-((i+s)%28))];
            end
            for (int j = 0; j < 48; j++)
                sk[6'(47-j)] = cd[6'(56-pc2_t[j])];
            if (dec) exp_k[4'(15-r)] = sk;
            else     exp_k[4'(r)]    = sk;
        end
    endtask

    function automatic logic [63:0] odd_key();
        logic [63:0] k;
        logic [7:0]  by;
        k = {$urandom(), $urandom()} & ~64'h0101010101010101;
        for (int b = 0; b < 8; b++) begin
            by = 8'(k >> (8*b));
            if (!(^by)) k = k | (64'h1 << (8*b));
        end
        return k;
    endfunction

    task automatic chk_reset(string tag);
        check({tag, "_sk"},   64'(subkey), 64'h0);
        check({tag, "_vld"},  64'(subkey_valid), 64'h0);
        check({tag, "_rnd"},  64'(round), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_done"}, 64'(done), 64'h0);
        check({tag, "_err"},  64'(key_err), 64'h0);
    endtask

    // mode: 0 ready high, 1 random ready, 2 stall 3 cycles at round 5,
    // 3 extra start at round 4, 4 reset at round 8.
    // Called and returns on a negedge.
    task automatic run_sched(input logic [63:0] k, input logic dec,
                             input int mode, output logic aborted);
        int   idx;
        int   cyc;
        int   stall;
        logic poked;
        logic rdy;
        aborted = 1'b0;
        model(k, dec);
        key = k;
        decrypt = dec;
        start = 1'b1;
        subkey_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        check("start_vld", 64'(subkey_valid), 64'h1);
        check("start_busy", 64'(busy), 64'h1);
        idx = 0;
        cyc = 0;
        stall = 0;
        poked = 1'b0;
        while (idx < 16 && cyc < 100) begin
            key = {$urandom(), $urandom()};
            decrypt = ~dec;
            check("vld", 64'(subkey_valid), 64'h1);
            check("sub", 64'(subkey), 64'(exp_k[idx[3:0]]));
            check("rnd", 64'(round), 64'(idx));
            check("busy", 64'(busy), 64'h1);
            if (mode == 4 && idx == 8) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_reset("abort");
                aborted = 1'b1;
                return;
            end
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 2) rdy = !(idx == 5 && stall < 3);
            else rdy = 1'b1;
            if (!rdy) stall++;
            if (mode == 3 && idx == 4 && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            subkey_ready = rdy;
            if (rdy) begin
                got_k[idx[3:0]] = subkey;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        subkey_ready = 1'($urandom_range(0, 1));
        check("sched_count", 64'(idx), 64'd16);
        if (mode == 0) check("sched_cycles", 64'(cyc), 64'd16);
        if (mode == 2) check("stall_cycles", 64'(stall), 64'd3);
        check("done", 64'(done), 64'h1);
        check("done_vld", 64'(subkey_valid), 64'h0);
        check("done_busy", 64'(busy), 64'h0);
    endtask

    task automatic idle_gap();
        @(negedge clk);
        check("idle_done", 64'(done), 64'h0);
        check("idle_vld", 64'(subkey_valid), 64'h0);
        check("idle_busy", 64'(busy), 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        decrypt = 1'b0;
        subkey_ready = 1'b0;
        key = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        subkey_ready = 1'b1;
        idle_gap();

        run_sched(KAT, 1'b0, 0, ab);
        enc_k = got_k;
        check("kat_enc_r0", 64'(got_k[0]), 64'(K1));
        check("kat_enc_r1", 64'(got_k[1]), 64'(K2));
        check("kat_enc_r15", 64'(got_k[15]), 64'(K16));

        run_sched(KAT, 1'b1, 0, ab);
        check("kat_dec_r0", 64'(got_k[0]), 64'(K16));
        check("kat_dec_r15", 64'(got_k[15]), 64'(K1));
        for (int i = 0; i < 16; i++)
            check("dec_rev", 64'(got_k[i]), 64'(enc_k[15-i]));
        idle_gap();

        run_sched(odd_key(), 1'($urandom_range(0, 1)), 2, ab);
        idle_gap();
        run_sched(odd_key(), 1'($urandom_range(0, 1)), 3, ab);
        idle_gap();

        run_sched(odd_key(), 1'b0, 4, ab);
        check("abort_flag", 64'(ab), 64'h1);
        idle_gap();
        run_sched(KAT, 1'b0, 0, ab);
        check("post_rst_k1", 64'(got_k[0]), 64'(K1));

        for (int t = 0; t < 6; t++) begin
            run_sched(odd_key(), 1'($urandom_range(0, 1)), 1, ab);
            if ($urandom_range(0, 1) == 1) idle_gap();
        end
        idle_gap();

`ifdef DES_KEY_PARITY_CHECK_EN
        key = KAT_BAD;
        decrypt = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("par_err", 64'(key_err), 64'h1);
        check("par_vld", 64'(subkey_valid), 64'h0);
        check("par_busy", 64'(busy), 64'h0);
        @(negedge clk);
        check("par_err_pulse", 64'(key_err), 64'h0);
        check("par_vld2", 64'(subkey_valid), 64'h0);
        check("par_busy2", 64'(busy), 64'h0);
`else
        run_sched(KAT_BAD, 1'b0, 0, ab);
        check("nopar_k1", 64'(got_k[0]), 64'(K1));
        check("nopar_err", 64'(key_err), 64'h0);
`endif
        idle_gap();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
